// File: rtl/demux_deser8.sv
// 1-to-8 serial-to-parallel deserializer: steers accepted serial bits into an
// 8-bit shadow register and publishes the completed word with a one-cycle pulse.
module demux_deser8 #(
   parameter int MSB_FIRST = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       din,
   input  logic       din_valid,
   input  logic       start,
   output logic [7:0] q,
   output logic       q_valid,
   output logic       busy,
   output logic       frame_abort,
   output logic [2:0] bit_cnt
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t     state_r, state_s;
   logic [2:0] sel_r, sel_s;
   logic [7:0] sh_r, sh_s;
   logic [7:0] q_r, q_s;
   logic       q_valid_r, q_valid_s;
   logic       busy_r, busy_s;
   logic       abort_r, abort_s;

   // Map the frame position onto a shadow-register slot for the chosen bit order.
   function automatic logic [2:0] slot_f(input logic [2:0] s);
      if (MSB_FIRST != 0) begin
         return 3'd7 - s;
      end else begin
         return s;
      end
   endfunction

   // Next-state and next-output logic for the IDLE/SHIFT frame controller.
   always_comb begin
      state_s   = state_r;
      sel_s     = sel_r;
      sh_s      = sh_r;
      q_s       = q_r;
      q_valid_s = 1'b0;
      abort_s   = 1'b0;
      case (state_r)
         IDLE: begin
            // Bits without start are idle-line noise and are dropped here.
            if (din_valid && start) begin
               sh_s[slot_f(3'd0)] = din;
               sel_s              = 3'd1;
               state_s            = SHIFT;
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            if (din_valid && start) begin
               // Restart wins even on the last slot; the old partial word is dropped.
               abort_s            = 1'b1;
               sh_s[slot_f(3'd0)] = din;
               sel_s              = 3'd1;
            end else if (din_valid) begin
               sh_s[slot_f(sel_r)] = din;
               if (sel_r == 3'd7) begin
                  q_s       = sh_s;
                  q_valid_s = 1'b1;
                  sel_s     = 3'd0;
                  state_s   = IDLE;
               end else begin
                  sel_s = sel_r + 3'd1;
               end
            end else begin
               state_s = SHIFT;
            end
         end
         default: begin
            state_s = IDLE;
            sel_s   = 3'd0;
         end
      endcase
      busy_s = (state_s == SHIFT);
   end

   // State, shadow and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         sel_r     <= 3'd0;
         sh_r      <= 8'h00;
         q_r       <= 8'h00;
         q_valid_r <= 1'b0;
         busy_r    <= 1'b0;
         abort_r   <= 1'b0;
      end else begin
         state_r   <= state_s;
         sel_r     <= sel_s;
         sh_r      <= sh_s;
         q_r       <= q_s;
         q_valid_r <= q_valid_s;
         busy_r    <= busy_s;
         abort_r   <= abort_s;
      end
   end

   assign q           = q_r;
   assign q_valid     = q_valid_r;
   assign busy        = busy_r;
   assign frame_abort = abort_r;
   assign bit_cnt     = sel_r;

endmodule

// File: tb/tb_demux_deser8.sv
// Scoreboard bench for demux_deser8: LSB-first and MSB-first instances share
// one stimulus stream; completed words are popped from per-instance queues.
module tb_demux_deser8;

   logic       clk;
   logic       rst_n;
   logic       din;
   logic       din_valid;
   logic       start;
   logic [7:0] q0, q1;
   logic       qv0, qv1, busy0, busy1, ab0, ab1;
   logic [2:0] cnt0, cnt1;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int qv_cnt = 0;
   int ab_cnt = 0;
   int qv_cyc_last = 0;
   int qv_cyc_prev = 0;
   logic [7:0] exp0_q[$];
   logic [7:0] exp1_q[$];

   demux_deser8 #(.MSB_FIRST(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .start(start),
      .q(q0), .q_valid(qv0), .busy(busy0), .frame_abort(ab0), .bit_cnt(cnt0)
   );

   demux_deser8 #(.MSB_FIRST(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .start(start),
      .q(q1), .q_valid(qv1), .busy(busy1), .frame_abort(ab1), .bit_cnt(cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] w);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = w[7 - i];
      return r;
   endfunction

   // Scoreboard: every q_valid pulse must match the oldest queued word.
   always @(negedge clk) begin
      if (rst_n) begin
         if (qv0) begin
            qv_cnt++;
            qv_cyc_prev = qv_cyc_last;
            qv_cyc_last = cyc;
            if (exp0_q.size() == 0) check_eq("lsb_spurious_valid", 32'd1, 32'd0);
            else check_eq("lsb_word", {24'd0, q0}, {24'd0, exp0_q.pop_front()});
         end
         if (qv1) begin
            if (exp1_q.size() == 0) check_eq("msb_spurious_valid", 32'd1, 32'd0);
            else check_eq("msb_word", {24'd0, q1}, {24'd0, exp1_q.pop_front()});
         end
         if (ab0) ab_cnt++;
      end
   end

   task automatic drive(input logic v, input logic s, input logic d);
      din_valid = v;
      start     = s;
      din       = d;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] w);
      exp0_q.push_back(w);
      exp1_q.push_back(rev8(w));
      for (int k = 0; k < 8; k++) drive(1'b1, (k == 0), w[k]);
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_q"}, {24'd0, q0, q1}, 32'd0);
      check_eq({tag, "_flags"}, {26'd0, qv0, qv1, busy0, busy1, ab0, ab1}, 32'd0);
      check_eq({tag, "_cnt"}, {26'd0, cnt0, cnt1}, 32'd0);
   endtask

   initial begin
      int stall_len[8];
      int base;
      logic [7:0] t1;

      rst_n = 1'b0;
      din = 1'b0; start = 1'b0; din_valid = 1'b0;
      repeat (3) drive(1'b0, 1'b0, 1'b0);
      check_reset_state("reset");
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0);

      // Spec stream 1,0,1,1,0,0,1,0 -> 4D LSB-first, B2 MSB-first
      t1 = 8'b0100_1101;
      exp0_q.push_back(8'h4D);
      exp1_q.push_back(8'hB2);
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, (k == 0), t1[k]);
         if (k == 0) check_eq("first_bit_cnt_busy", {28'd0, busy0, cnt0}, {28'd0, 1'b1, 3'd1});
         if (k < 7) check_eq("no_early_valid", {31'd0, qv0}, 32'd0);
      end
      check_eq("n8_valid", {30'd0, qv0, qv1}, 32'd3);
      check_eq("n8_q", {16'd0, q0, q1}, {16'd0, 8'h4D, 8'hB2});
      check_eq("n8_idle", {28'd0, busy0, cnt0}, 32'd0);
      drive(1'b0, 1'b0, 1'b0);
      check_eq("pulse_one_cycle", {31'd0, qv0}, 32'd0);

      // Stalls of 1, 3 and 10 cycles at random bit positions
      for (int k = 0; k < 8; k++) stall_len[k] = 0;
      stall_len[$urandom_range(0, 1)] = 1;
      stall_len[$urandom_range(2, 4)] = 3;
      stall_len[$urandom_range(5, 6)] = 10;
      base = qv_cnt;
      exp0_q.push_back(8'hA5);
      exp1_q.push_back(rev8(8'hA5));
      for (int k = 0; k < 8; k++) begin
         logic [7:0] w;
         w = 8'hA5;
         drive(1'b1, (k == 0), w[k]);
         for (int j = 0; j < stall_len[k]; j++) begin
            drive(1'b0, 1'($urandom), 1'($urandom));
            check_eq("stall_cnt_frozen", {29'd0, cnt0}, k + 1);
         end
      end
      drive(1'b0, 1'b0, 1'b0);
      check_eq("stall_single_valid", qv_cnt - base, 32'd1);
      check_eq("stall_q", {24'd0, q0}, {24'd0, 8'hA5});

      // Abort after 5 bits, then restart with 3C
      base = ab_cnt;
      for (int k = 0; k < 5; k++) drive(1'b1, (k == 0), 1'b1);
      check_eq("partial_cnt", {29'd0, cnt0}, 32'd5);
      check_eq("partial_q_held", {24'd0, q0}, {24'd0, 8'hA5});
      exp0_q.push_back(8'h3C);
      exp1_q.push_back(rev8(8'h3C));
      for (int k = 0; k < 8; k++) begin
         logic [7:0] w;
         w = 8'h3C;
         drive(1'b1, (k == 0), w[k]);
         if (k == 0) begin
            check_eq("abort_pulse", {30'd0, ab0, ab1}, 32'd3);
            check_eq("abort_q_held", {23'd0, qv0, q0}, {23'd0, 1'b0, 8'hA5});
            check_eq("abort_cnt", {28'd0, busy0, cnt0}, {28'd0, 1'b1, 3'd1});
         end
         if (k == 1) check_eq("abort_one_cycle", {31'd0, ab0}, 32'd0);
      end
      drive(1'b0, 1'b0, 1'b0);
      check_eq("abort_final_q", {24'd0, q0}, {24'd0, 8'h3C});

      // Restart on the last slot
      for (int k = 0; k < 7; k++) drive(1'b1, (k == 0), 1'b0);
      check_eq("sel7_cnt", {29'd0, cnt0}, 32'd7);
      send_frame(8'h5A);
      drive(1'b0, 1'b0, 1'b0);
      check_eq("abort_count", ab_cnt - base, 32'd2);

      // Back-to-back FF then 00
      send_frame(8'hFF);
      check_eq("b2b_first", {23'd0, qv0, q0}, {23'd0, 1'b1, 8'hFF});
      send_frame(8'h00);
      check_eq("b2b_second", {23'd0, qv0, q0}, {23'd0, 1'b1, 8'h00});
      drive(1'b0, 1'b0, 1'b0);
      check_eq("b2b_spacing", qv_cyc_last - qv_cyc_prev, 32'd8);

      // Idle-line noise without start
      base = qv_cnt;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 1'b0, 1'($urandom));
         check_eq("noise_idle", {19'd0, busy0, cnt0, qv0, q0}, 32'd0);
      end
      check_eq("noise_no_valid", qv_cnt - base, 32'd0);

      // Asynchronous reset after 4 bits
      for (int k = 0; k < 4; k++) drive(1'b1, (k == 0), 1'b1);
      check_eq("pre_reset_cnt", {29'd0, cnt0}, 32'd4);
      #1 rst_n = 1'b0;
      #1 check_reset_state("midreset");
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      send_frame(8'h81);
      drive(1'b0, 1'b0, 1'b0);
      check_eq("post_reset_q", {16'd0, q0, q1}, {16'd0, 8'h81, 8'h81});

      check_eq("scoreboard_empty", exp0_q.size() + exp1_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
